// File: rtl/disp_src_sel.sv
// disp_src_sel: N-channel display-source selector with browsing, edit blink, freeze and idle auto-return
module disp_src_sel #(
  parameter int NCH = 4,
  parameter int NF = 3,
  parameter int FW = 8,
  parameter int TIMEOUT = 10,
  parameter logic [FW-1:0] BLANK = {FW{1'b1}},
  localparam int CW = $clog2(NCH),
  localparam int FLW = (NF > 1) ? $clog2(NF) : 1,
  localparam int W = NF * FW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               tick_blink,
  input  logic               mode_next,
  input  logic               field_next,
  input  logic               edit_en,
  input  logic               hold,
  input  logic [NCH*W-1:0]   ch_data,
  output logic [W-1:0]       tm,
  output logic [CW-1:0]      cur_ch,
  output logic [FLW-1:0]     cur_field,
  output logic               not_live
);
  typedef enum logic [1:0] {LIVE, BROWSE, EDIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [FLW-1:0] field_q, field_d;
  logic phase_q, phase_d;
  logic [7:0] idle_q, idle_d;
  logic [W-1:0] tm_q, tm_d, word;
  logic not_live_q, not_live_d;
  logic fld_hit;
  logic [W-1:0] words [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_words
    assign words[k] = ch_data[k*W +: W];
  end
  // channel, field, blink phase and idle-timeout bookkeeping; buttons outrank expiry
  always_comb begin
    ch_d = ch_q;
    field_d = field_q;
    phase_d = phase_q;
    idle_d = idle_q;
    fld_hit = 1'b0;
    if (mode_next) begin
      ch_d = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
      field_d = '0;
      idle_d = '0;
    end else if (field_next && state_q != LIVE) begin
      idle_d = '0;
      if (state_q == EDIT) begin
        field_d = (field_q == FLW'(NF - 1)) ? '0 : field_q + FLW'(1);
        phase_d = 1'b1;
        fld_hit = 1'b1;
      end
    end else if (tick_1hz && state_q != LIVE) begin
      if (idle_q + 8'd1 == 8'(TIMEOUT)) begin
        ch_d = '0;
        field_d = '0;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end
    state_d = (ch_d == '0) ? LIVE : edit_en ? EDIT : BROWSE;
    if (state_d == LIVE) idle_d = '0;
    if (state_d != EDIT) begin
      phase_d = 1'b1;
    end else if (state_q != EDIT) begin
      phase_d = 1'b1;
      field_d = '0;
    end else if (tick_blink && !fld_hit) begin
      phase_d = ~phase_q;
    end
    not_live_d = (ch_d != '0);
  end
  // display word: selected channel with the edited field blanked in the off phase, frozen by hold
  always_comb begin
    word = words[ch_q];
    for (int f = 0; f < NF; f++)
      if (state_q == EDIT && !phase_q && field_q == FLW'(f)) word[(NF-1-f)*FW +: FW] = BLANK;
    tm_d = hold ? tm_q : word;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LIVE;
      ch_q <= '0;
      field_q <= '0;
      phase_q <= 1'b1;
      idle_q <= '0;
      tm_q <= '0;
      not_live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      field_q <= field_d;
      phase_q <= phase_d;
      idle_q <= idle_d;
      tm_q <= tm_d;
      not_live_q <= not_live_d;
    end
  end
  assign tm = tm_q;
  assign cur_ch = ch_q;
  assign cur_field = field_q;
  assign not_live = not_live_q;
endmodule

// File: tb/tb_disp_src_sel.sv
// tb_disp_src_sel: scoreboard bench for disp_src_sel with default parameters
module tb_disp_src_sel;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_1hz = 1'b0, tick_blink = 1'b0, mode_next = 1'b0, field_next = 1'b0;
  logic edit_en = 1'b0, hold = 1'b0;
  logic [95:0] ch_data;
  logic [23:0] tm;
  logic [1:0] cur_ch;
  logic [1:0] cur_field;
  logic not_live;
  logic [23:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  disp_src_sel dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_blink(tick_blink),
    .mode_next(mode_next), .field_next(field_next), .edit_en(edit_en), .hold(hold),
    .ch_data(ch_data), .tm(tm), .cur_ch(cur_ch), .cur_field(cur_field), .not_live(not_live)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic mn, input logic fn, input logic t1, input logic tb, input logic [23:0] e);
    logic [23:0] x;
    mode_next = mn;
    field_next = fn;
    tick_1hz = t1;
    tick_blink = tb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mode_next = 1'b0;
    field_next = 1'b0;
    tick_1hz = 1'b0;
    tick_blink = 1'b0;
    x = exp_q.pop_front();
    chk(tag, {8'h0, tm}, {8'h0, x});
  endtask
  initial begin
    logic [23:0] w [4];
    w[0] = 24'h123456; w[1] = 24'h070000; w[2] = 24'h080000; w[3] = 24'h090000;
    ch_data = {w[3], w[2], w[1], w[0]};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tm", {8'h0, tm}, 32'h0);
    chk("rst_ch", {30'h0, cur_ch}, 32'h0);
    chk("rst_nl", {31'h0, not_live}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("live_tm", 1'b0, 1'b0, 1'b0, 1'b0, w[0]);
    chk("live_ch", {30'h0, cur_ch}, 32'h0);
    chk("live_nl", {31'h0, not_live}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc("mode_tm_old", 1'b1, 1'b0, 1'b0, 1'b0, w[(i-1)%4]);
      chk("mode_ch", {30'h0, cur_ch}, 32'(i % 4));
      chk("mode_field", {30'h0, cur_field}, 32'h0);
      cyc("mode_tm_new", 1'b0, 1'b0, 1'b0, 1'b0, w[i%4]);
      chk("mode_nl", {31'h0, not_live}, 32'((i % 4) != 0));
    end
    cyc("to_ch1", 1'b1, 1'b0, 1'b0, 1'b0, w[0]);
    edit_en = 1'b1;
    cyc("enter_edit", 1'b0, 1'b0, 1'b0, 1'b0, w[1]);
    chk("edit_field0", {30'h0, cur_field}, 32'h0);
    cyc("field_next", 1'b0, 1'b1, 1'b0, 1'b0, w[1]);
    chk("edit_field1", {30'h0, cur_field}, 32'h1);
    cyc("blink1_edge", 1'b0, 1'b0, 1'b0, 1'b1, w[1]);
    cyc("blink_off", 1'b0, 1'b0, 1'b0, 1'b0, 24'h07FF00);
    cyc("blink2_edge", 1'b0, 1'b0, 1'b0, 1'b1, 24'h07FF00);
    cyc("blink_on", 1'b0, 1'b0, 1'b0, 1'b0, w[1]);
    edit_en = 1'b0;
    cyc("to_ch2", 1'b1, 1'b0, 1'b0, 1'b0, w[1]);
    for (int i = 1; i <= 9; i++) cyc("idle_tick", 1'b0, 1'b0, 1'b1, 1'b0, w[2]);
    chk("pre_timeout_ch", {30'h0, cur_ch}, 32'h2);
    cyc("timeout_tick", 1'b0, 1'b0, 1'b1, 1'b0, w[2]);
    chk("timeout_ch", {30'h0, cur_ch}, 32'h0);
    chk("timeout_nl", {31'h0, not_live}, 32'h0);
    cyc("timeout_tm", 1'b0, 1'b0, 1'b0, 1'b0, w[0]);
    cyc("re_ch1", 1'b1, 1'b0, 1'b0, 1'b0, w[0]);
    cyc("re_ch2", 1'b1, 1'b0, 1'b0, 1'b0, w[1]);
    for (int i = 1; i <= 9; i++) cyc("idle_tick2", 1'b0, 1'b0, 1'b1, 1'b0, w[2]);
    cyc("cancel_tick", 1'b1, 1'b0, 1'b1, 1'b0, w[2]);
    chk("cancel_ch", {30'h0, cur_ch}, 32'h3);
    for (int i = 1; i <= 9; i++) cyc("after_cancel", 1'b0, 1'b0, 1'b1, 1'b0, w[3]);
    chk("cleared_ch", {30'h0, cur_ch}, 32'h3);
    cyc("timeout2_tick", 1'b0, 1'b0, 1'b1, 1'b0, w[3]);
    chk("timeout2_ch", {30'h0, cur_ch}, 32'h0);
    cyc("timeout2_tm", 1'b0, 1'b0, 1'b0, 1'b0, w[0]);
    hold = 1'b1;
    cyc("hold_a", 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
    w[0] = 24'h123457;
    ch_data = {w[3], w[2], w[1], w[0]};
    cyc("hold_b", 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
    cyc("hold_c", 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
    hold = 1'b0;
    cyc("hold_release", 1'b0, 1'b0, 1'b0, 1'b0, 24'h123457);
    edit_en = 1'b1;
    cyc("edit_ch1", 1'b1, 1'b0, 1'b0, 1'b0, w[0]);
    cyc("edit_ch2", 1'b1, 1'b0, 1'b0, 1'b0, w[1]);
    chk("edit_ch2_ch", {30'h0, cur_ch}, 32'h2);
    cyc("edit_blink", 1'b0, 1'b0, 1'b0, 1'b1, w[2]);
    cyc("edit_off_f0", 1'b0, 1'b0, 1'b0, 1'b0, 24'hFF0000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tm", {8'h0, tm}, 32'h0);
    chk("arst_ch", {30'h0, cur_ch}, 32'h0);
    chk("arst_field", {30'h0, cur_field}, 32'h0);
    chk("arst_nl", {31'h0, not_live}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("post_rst_tm", 1'b0, 1'b0, 1'b0, 1'b1, w[0]);
    cyc("post_rst_tm2", 1'b0, 1'b0, 1'b0, 1'b0, w[0]);
    chk("post_rst_ch", {30'h0, cur_ch}, 32'h0);
    chk("post_rst_nl", {31'h0, not_live}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
